// File: rtl/irq_evt_ctrl_v1_pkg.sv
// ---------------------------------------------------------------------------
// irq_evt_ctrl_v1_pkg
//   Shared definitions for the interrupt/event controller: SFR offsets
//   relative to BASE_ADDR, SFR field layouts, the handshake FSM state type
//   and a helper that sizes the interrupt id field.
// ---------------------------------------------------------------------------
package irq_evt_ctrl_v1_pkg;

  // Byte offsets of the four SFRs relative to BASE_ADDR
  localparam int IRQ_CTRL_OFS = 0;
  localparam int IRQ_EN_OFS   = 4;
  localparam int IRQ_PEND_OFS = 8;
  localparam int IRQ_ID_OFS   = 12;

  // Largest number of event sources the SFR layout can describe
  localparam int IRQ_MAX_SRC  = 31;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SERV = 2'd2
  } irq_fsm_t;

  // IRQ_CTRL low bits: [0] global interrupt enable, [1] end-of-interrupt strobe
  typedef struct packed {
    logic eoi;
    logic gie;
  } irq_ctrl_t;

  typedef struct packed {
    logic [IRQ_MAX_SRC-1:0] src;
  } irq_en_t;

  typedef struct packed {
    logic [IRQ_MAX_SRC-1:0] src;
  } irq_pend_t;

  // IRQ_ID contents before placement on the bus (active goes to the MSB)
  typedef struct packed {
    logic       active;
    logic [4:0] id;
  } irq_id_t;

  // Width of the id field; a single-source build still needs one bit
  function automatic int irq_id_width(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

endpackage

// File: rtl/irq_evt_ctrl_v1_if.sv
// ---------------------------------------------------------------------------
// irq_evt_ctrl_v1_if
//   Bundles the SFR bus, the event lines and the core-side interrupt
//   handshake of the controller.
//   master : system side (drives bus, events, ack; receives read data / irq)
//   slave  : controller side
//   Signals:
//     sys_clk_en    global enable, state holds when 0
//     sys_addr      SFR address
//     sys_wr_en     SFR write strobe
//     sys_sw_value  SFR write data
//     evt_in        peripheral event lines
//     irq_ack       core accepts current request
//     sfr_rd_dout   read data of addressed SFR (0 if not ours)
//     irq_req       interrupt request to the core
//     irq_id        id of requested / in-service source
// ---------------------------------------------------------------------------
interface irq_evt_ctrl_v1_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_SRC      = 8
);

  localparam int ID_W = irq_evt_ctrl_v1_pkg::irq_id_width(N_SRC);

  logic                  sys_clk_en;
  logic [ADDR_WIDTH-1:0] sys_addr;
  logic                  sys_wr_en;
  logic [DATA_WIDTH-1:0] sys_sw_value;
  logic [N_SRC-1:0]      evt_in;
  logic                  irq_ack;
  logic [DATA_WIDTH-1:0] sfr_rd_dout;
  logic                  irq_req;
  logic [ID_W-1:0]       irq_id;

  modport master (
    output sys_clk_en, sys_addr, sys_wr_en, sys_sw_value, evt_in, irq_ack,
    input  sfr_rd_dout, irq_req, irq_id
  );

  modport slave (
    input  sys_clk_en, sys_addr, sys_wr_en, sys_sw_value, evt_in, irq_ack,
    output sfr_rd_dout, irq_req, irq_id
  );

endinterface

// File: rtl/irq_evt_ctrl_v1_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
//   Fixed-priority encoder: index 0 is the highest priority.
//   Ports:
//     req    in   N_SRC   candidate sources (pending and enabled)
//     valid  out  1       at least one candidate
//     id     out  ID_W    lowest set index of req (0 when none)
// ---------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scan from the top down so the last hit, i.e. the lowest index, sticks
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_evt_ctrl_v1.sv
// ---------------------------------------------------------------------------
// irq_evt_ctrl_v1
//   Interrupt/event controller. Rising edges on evt_in set SW-visible pending
//   flags; pending & enabled sources are resolved by fixed priority (index 0
//   highest) and presented to the core through a req / ack / EOI handshake.
//
//   SFRs (byte offsets from BASE_ADDR):
//     +0  IRQ_CTRL  [0] GIE rw, [1] EOI write-1 strobe (reads 0)
//     +4  IRQ_EN    [N_SRC-1:0] rw
//     +8  IRQ_PEND  [N_SRC-1:0] HW set, write-1-to-clear
//     +12 IRQ_ID    [ID_W-1:0] current id, [DATA_WIDTH-1] ACTIVE, ro
//
//   Ports:
//     sys_clk  in  system clock (only clock)
//     sys_rst  in  asynchronous active-high reset
//     bus      irq_evt_ctrl_v1_if.slave (SFR bus, events, irq handshake)
//
//   Build option:
//     IRQ_EVT_SYNC_EN  when defined, each evt_in bit passes a 2-flop
//                      synchronizer before edge detection (+2 cycles latency)
// ---------------------------------------------------------------------------
module irq_evt_ctrl_v1
  import irq_evt_ctrl_v1_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          N_SRC      = 8
) (
  input logic              sys_clk,
  input logic              sys_rst,
  irq_evt_ctrl_v1_if.slave bus
);

  localparam int ID_W = irq_id_width(N_SRC);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = ADDR_WIDTH'(BASE_ADDR + IRQ_CTRL_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_EN   = ADDR_WIDTH'(BASE_ADDR + IRQ_EN_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PEND = ADDR_WIDTH'(BASE_ADDR + IRQ_PEND_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ID   = ADDR_WIDTH'(BASE_ADDR + IRQ_ID_OFS);

  // State registers
  logic             gie_q, gie_d;
  logic [N_SRC-1:0] en_q, en_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] evt_prev_q, evt_prev_d;
  irq_fsm_t         state_q, state_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;

  // Decode / datapath
  irq_ctrl_t        ctrl_wr;
  logic             sel_ctrl, sel_en, sel_pend, sel_id;
  logic             eoi;
  logic [N_SRC-1:0] evt_s;
  logic [N_SRC-1:0] evt_rise;
  logic [N_SRC-1:0] pend_w1c;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] cand;
  logic             enc_valid;
  logic [ID_W-1:0]  enc_id;
  logic             irq_req_o;
  logic             active;

  // -------------------------------------------------------------------------
  // Event input stage
  // -------------------------------------------------------------------------
`ifdef IRQ_EVT_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync1_d;
  logic [N_SRC-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.evt_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else if (bus.sys_clk_en) begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign evt_s = sync2_q;
`else
  assign evt_s = bus.evt_in;
`endif

  // -------------------------------------------------------------------------
  // SFR write decode and pending-flag update
  // -------------------------------------------------------------------------
  always_comb begin
    sel_ctrl = (bus.sys_addr == ADDR_CTRL);
    sel_en   = (bus.sys_addr == ADDR_EN);
    sel_pend = (bus.sys_addr == ADDR_PEND);
    sel_id   = (bus.sys_addr == ADDR_ID);

    ctrl_wr  = irq_ctrl_t'(bus.sys_sw_value[1:0]);
    eoi      = bus.sys_wr_en && sel_ctrl && ctrl_wr.eoi;
    gie_d    = (bus.sys_wr_en && sel_ctrl) ? ctrl_wr.gie : gie_q;
    en_d     = (bus.sys_wr_en && sel_en) ? bus.sys_sw_value[N_SRC-1:0] : en_q;
    pend_w1c = (bus.sys_wr_en && sel_pend) ? bus.sys_sw_value[N_SRC-1:0] : '0;

    evt_rise   = evt_s & ~evt_prev_q;
    evt_prev_d = evt_s;

    ack_clr = '0;
    if (state_q == IRQ_REQ && bus.irq_ack) begin
      ack_clr[irq_id_q] = 1'b1;
    end

    // A new hardware edge beats any clear (SW W1C or ack) in the same cycle
    pend_d = (pend_q & ~pend_w1c & ~ack_clr) | evt_rise;

    // Only raise a request for a source that stays pending and enabled
    // after this cycle's SW writes, so a same-cycle revoke never glitches irq_req
    cand = pend_q & en_q & pend_d & en_d;
  end

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (cand),
    .valid (enc_valid),
    .id    (enc_id)
  );

  // -------------------------------------------------------------------------
  // Handshake FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IRQ_IDLE;
      irq_id_q <= '0;
    end else if (bus.sys_clk_en) begin
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
    end
  end

  // -------------------------------------------------------------------------
  // Handshake FSM: next state
  //   REQ withdraws when SW revokes GIE, EN or PEND of the requested source;
  //   an ack in the same cycle takes precedence since the core already
  //   committed to servicing it.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IRQ_IDLE: begin
        if (gie_q && gie_d && enc_valid) begin
          state_d  = IRQ_REQ;
          irq_id_d = enc_id;
        end
      end
      IRQ_REQ: begin
        if (bus.irq_ack) begin
          state_d = IRQ_SERV;
        end else if (!gie_d || !pend_d[irq_id_q] || !en_d[irq_id_q]) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_SERV: begin
        if (eoi) begin
          state_d = IRQ_IDLE;
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    irq_req_o = (state_q == IRQ_REQ);
    active    = (state_q != IRQ_IDLE);
  end

  assign bus.irq_req = irq_req_o;
  assign bus.irq_id  = irq_id_q;

  // -------------------------------------------------------------------------
  // SFR storage
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gie_q      <= 1'b0;
      en_q       <= '0;
      pend_q     <= '0;
      evt_prev_q <= '0;
    end else if (bus.sys_clk_en) begin
      gie_q      <= gie_d;
      en_q       <= en_d;
      pend_q     <= pend_d;
      evt_prev_q <= evt_prev_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read path: each SFR gates its word with its own select, words are ORed
  // -------------------------------------------------------------------------
  irq_en_t               en_view;
  irq_pend_t             pend_view;
  irq_id_t               id_view;
  logic [DATA_WIDTH-1:0] rd_ctrl, rd_en, rd_pend, rd_id;

  always_comb begin
    en_view                  = '0;
    en_view.src[N_SRC-1:0]   = en_q;
    pend_view                = '0;
    pend_view.src[N_SRC-1:0] = pend_q;
    id_view                  = '0;
    id_view.id               = 5'(irq_id_q);
    id_view.active           = active;

    rd_ctrl    = '0;
    rd_ctrl[0] = gie_q;

    rd_en              = '0;
    rd_en[N_SRC-1:0]   = en_view.src[N_SRC-1:0];

    rd_pend            = '0;
    rd_pend[N_SRC-1:0] = pend_view.src[N_SRC-1:0];

    rd_id                 = '0;
    rd_id[ID_W-1:0]       = id_view.id[ID_W-1:0];
    rd_id[DATA_WIDTH-1]   = id_view.active;

    bus.sfr_rd_dout = ({DATA_WIDTH{sel_ctrl}} & rd_ctrl)
                    | ({DATA_WIDTH{sel_en}}   & rd_en)
                    | ({DATA_WIDTH{sel_pend}} & rd_pend)
                    | ({DATA_WIDTH{sel_id}}   & rd_id);
  end

endmodule
